text_overlay: RTL and testbench

- Character-cell text renderer between the VGA timing generator and the RGB output mux.
- Maps the current pixel to an 8x8 character cell and reads a 4-bit character code from an internal text buffer.
- Drives the font ROM row lookup (code + rownum, combinational 8-bit row back), then serializes the returned row into a 1-bit pixel.
- Adds a frame-counted blinking block cursor. Sync and blank signals are delayed to match the pixel latency.

---
 rtl/text_overlay.sv | 139 +++++++++++++
 tb/tb_text_overlay.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/text_overlay.sv
// text_overlay: 8x8 character-cell text renderer with a frame-counted blinking
// block cursor. Two-cycle pipeline from pixel coordinates to pix_on; the font
// ROM is looked up combinationally between stage 1 and stage 2.
module text_overlay #(
  parameter int X0           = 0,
  parameter int Y0           = 0,
  parameter int COLS         = 16,
  parameter int ROWS         = 4,
  parameter int BLINK_FRAMES = 30,
  parameter int AW           = 6
) (
  input  logic          VGA_clk,
  input  logic          reset_n,
  input  logic [9:0]    hcount,
  input  logic [9:0]    vcount,
  input  logic          video_on_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_char,
  input  logic          cursor_en,
  input  logic [AW-1:0] cursor_addr,
  output logic          font_en,
  output logic [3:0]    font_char,
  output logic [2:0]    font_row,
  input  logic [7:0]    font_pixels,
  output logic          pix_on,
  output logic          video_on_out,
  output logic          hsync_out,
  output logic          vsync_out
);
  localparam int NCELL = COLS * ROWS;
  localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int CW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // stage 0: pixel -> cell mapping
  logic [9:0]    dx, dy;
  logic          in_region;
  logic [AW-1:0] addr;

  assign dx = hcount - 10'(X0);
  assign dy = vcount - 10'(Y0);
  assign in_region = video_on_in
                   & (32'(hcount) >= 32'(X0)) & (32'(hcount) < 32'(X0 + 8*COLS))
                   & (32'(vcount) >= 32'(Y0)) & (32'(vcount) < 32'(Y0 + 8*ROWS));
  // truncation is harmless: only in-region addresses (< NCELL) are ever used
  assign addr = AW'(dy[9:3]) * AW'(COLS) + AW'(dx[9:3]);

  // stage 1 registers
  logic [IW-1:0] addr_q;
  logic [2:0]    bitsel_q, rownum_q;
  logic          in_region_q, cursor_hit_q;
  logic          vo_q, hs_q, vs_q;

  // blink state
  logic          tick_raw, tick_d, frame_tick, blink_phase;
  logic [CW-1:0] blink_cnt;

  // text buffer
  logic [3:0] text_buf [NCELL];

  // stage 1: register cell address, glyph bit/row select and cursor match
  always_ff @(posedge VGA_clk) begin
    if (!reset_n) begin
      addr_q       <= '0;
      bitsel_q     <= '0;
      rownum_q     <= '0;
      in_region_q  <= 1'b0;
      cursor_hit_q <= 1'b0;
      vo_q         <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
    end else begin
      addr_q       <= addr[IW-1:0];
      bitsel_q     <= dx[2:0];
      rownum_q     <= dy[2:0];
      in_region_q  <= in_region;
      // out-of-range cursor_addr never equals an in-region addr
      cursor_hit_q <= cursor_en & (addr == cursor_addr) & in_region;
      vo_q         <= video_on_in;
      hs_q         <= hsync_in;
      vs_q         <= vsync_in;
    end
  end

  // font ROM request; reads see the buffer before this cycle's write
  assign font_en   = in_region_q;
  assign font_char = in_region_q ? text_buf[addr_q] : 4'hF;
  assign font_row  = rownum_q;

  // stage 2: pick the glyph bit, apply cursor inversion, delay syncs
  always_ff @(posedge VGA_clk) begin
    if (!reset_n) begin
      pix_on       <= 1'b0;
      video_on_out <= 1'b0;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
    end else begin
      pix_on       <= in_region_q &
                      (font_pixels[3'd7 - bitsel_q] ^ (cursor_hit_q & blink_phase));
      video_on_out <= vo_q;
      hsync_out    <= hs_q;
      vsync_out    <= vs_q;
    end
  end

  // text buffer writes; out-of-range addresses are dropped
  always_ff @(posedge VGA_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NCELL; i++) text_buf[i] <= 4'hF;
    end else if (wr_en && (32'(wr_addr) < 32'(NCELL))) begin
      text_buf[wr_addr[IW-1:0]] <= wr_char;
    end
  end

  // frame tick fires once on entry to (0,0), even if the scan stalls there
  assign tick_raw   = (hcount == 10'd0) && (vcount == 10'd0);
  assign frame_tick = tick_raw & ~tick_d;

  // blink counter: phase toggles every BLINK_FRAMES frame ticks
  always_ff @(posedge VGA_clk) begin
    if (!reset_n) begin
      tick_d      <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      tick_d <= tick_raw;
      if (frame_tick) begin
        if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_text_overlay.sv
// tb_text_overlay: directed and randomized stimulus against a frame-level
// reference model (cell lookup by division, tick counting, 2-deep delay).
module tb_text_overlay;
  localparam int COLS  = 16;
  localparam int ROWS  = 4;
  localparam int BF    = 30;
  localparam int AW    = 7;
  localparam int NCELL = COLS * ROWS;

  logic          VGA_clk = 1'b0;
  logic          reset_n;
  logic [9:0]    hcount, vcount;
  logic          video_on_in, hsync_in, vsync_in;
  logic          wr_en;
  logic [AW-1:0] wr_addr, cursor_addr;
  logic [3:0]    wr_char;
  logic          cursor_en;
  logic          font_en;
  logic [3:0]    font_char;
  logic [2:0]    font_row;
  logic [7:0]    font_pixels, junk;
  logic          pix_on, video_on_out, hsync_out, vsync_out;

  always #5 VGA_clk = ~VGA_clk;

  // font ROM stand-in; code 15 is blank
  function automatic logic [7:0] rom(input logic [3:0] c, input logic [2:0] r);
    if (c == 4'hF) return 8'h00;
    if (c == 4'h1 && r == 3'd1) return 8'h70;
    if (c == 4'h0 && r == 3'd0) return 8'h7C;
    return {c, 1'b1, r} ^ 8'h5A;
  endfunction

  // garbage on the ROM bus whenever the DUT is not requesting a row
  assign font_pixels = font_en ? rom(font_char, font_row) : junk;
  always @(negedge VGA_clk) junk = 8'($urandom);

  text_overlay #(.X0(0), .Y0(0), .COLS(COLS), .ROWS(ROWS),
                 .BLINK_FRAMES(BF), .AW(AW)) dut (
    .VGA_clk(VGA_clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .video_on_in(video_on_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .cursor_en(cursor_en), .cursor_addr(cursor_addr),
    .font_en(font_en), .font_char(font_char), .font_row(font_row),
    .font_pixels(font_pixels), .pix_on(pix_on), .video_on_out(video_on_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out));

  typedef struct packed {
    logic en; logic [3:0] ch; logic [2:0] row;
    logic pix, vo, hs, vs;
  } ent_t;
  localparam ent_t RST_ENT = '{en: 1'b0, ch: 4'hF, row: 3'd0,
                               pix: 1'b0, vo: 1'b0, hs: 1'b0, vs: 1'b0};

  ent_t       m1, m2;
  logic [3:0] mbuf [NCELL];
  int         t;
  bit         prev, armed;
  int         n_tests, n_fail;
  bit         hp[$], hh[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one pixel clock: model the current inputs, clock, compare outputs
  task automatic step();
    ent_t       e;
    bit         rst, raw, phase, inr, hit;
    int         idx;
    logic [7:0] fp;
    rst = !reset_n;
    e   = RST_ENT;
    if (rst) begin
      for (int i = 0; i < NCELL; i++) mbuf[i] = 4'hF;
      t = 0; prev = 0;
    end else begin
      if (wr_en && int'(wr_addr) < NCELL) mbuf[int'(wr_addr)] = wr_char;
      raw = (hcount == 0 && vcount == 0);
      if (raw && !prev) t++;
      prev  = raw;
      phase = ((t / BF) % 2) == 0;
      inr   = video_on_in && int'(hcount) < 8*COLS && int'(vcount) < 8*ROWS;
      e.en  = inr;
      e.row = 3'(int'(vcount) % 8);
      e.vo  = video_on_in; e.hs = hsync_in; e.vs = vsync_in;
      if (inr) begin
        idx   = (int'(vcount) / 8) * COLS + int'(hcount) / 8;
        e.ch  = mbuf[idx];
        fp    = rom(e.ch, e.row);
        hit   = cursor_en && int'(cursor_addr) == idx;
        e.pix = fp[7 - int'(hcount) % 8] ^ (hit && phase);
      end
    end
    @(posedge VGA_clk);
    if (rst) begin m1 = RST_ENT; m2 = RST_ENT; armed = 1; end
    else begin m2 = m1; m1 = e; end
    #1;
    if (armed) begin
      chk("font_en",      font_en,      m1.en);
      chk("font_char",    font_char,    m1.ch);
      chk("font_row",     font_row,     m1.row);
      chk("pix_on",       pix_on,       m2.pix);
      chk("video_on_out", video_on_out, m2.vo);
      chk("hsync_out",    hsync_out,    m2.hs);
      chk("vsync_out",    vsync_out,    m2.vs);
    end
    hp.push_back(pix_on);
    hh.push_back(hsync_out);
  endtask

  task automatic px(input int h, input int v);
    hcount = 10'(h); vcount = 10'(v);
    step();
  endtask

  task automatic wr(input int a, input int c);
    wr_en = 1; wr_addr = AW'(a); wr_char = 4'(c);
    px(300, 300);
    wr_en = 0;
  endtask

  task automatic clr();
    hp.delete(); hh.delete();
  endtask

  // pixel i of a scan lands at hp[i+1]; pack 8 of them MSB-first
  function automatic logic [7:0] row_bits();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = hp[i+1];
    return b;
  endfunction

  initial begin
    int n, lit, first, lows;
    n_tests = 0; n_fail = 0; armed = 0; t = 0; prev = 0;
    m1 = RST_ENT; m2 = RST_ENT;
    reset_n = 0; video_on_in = 1; hsync_in = 1; vsync_in = 1;
    wr_en = 0; wr_addr = '0; wr_char = '0; cursor_en = 0; cursor_addr = '0;
    hcount = 10'd300; vcount = 10'd300;

    // reset held with everything toggling
    for (int i = 0; i < 3; i++) begin
      video_on_in = 1'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      wr_en = 1; wr_addr = AW'($urandom_range(0, 63)); wr_char = 4'($urandom);
      cursor_en = 1;
      px($urandom_range(0, 127), $urandom_range(0, 31));
      chk("rst_pix", pix_on, 0);
      chk("rst_char", font_char, 4'hF);
      chk("rst_hs", hsync_out, 0);
    end
    wr_en = 0; cursor_en = 0; video_on_in = 1; hsync_in = 1; vsync_in = 1;
    reset_n = 1;

    // blank buffer renders nothing
    clr();
    for (int v = 0; v < 36; v++) for (int h = 0; h < 136; h++) px(h, v);
    px(300, 300); px(300, 300);
    lit = 0;
    foreach (hp[i]) lit += int'(hp[i]);
    chk("blank_frame", lit, 0);

    // code 1, glyph row 1
    wr(0, 1);
    clr();
    px(0, 1);
    chk("g1_row", font_row, 1);
    chk("g1_char", font_char, 1);
    for (int h = 1; h < 8; h++) px(h, 1);
    px(300, 300); px(300, 300);
    chk("g1_bits", row_bits(), 8'h70);

    // code 0 in cell 17, then one pixel past the right edge
    wr(17, 0);
    clr();
    for (int h = 8; h < 16; h++) px(h, 8);
    px(300, 300); px(300, 300);
    chk("c17_bits", row_bits(), 8'h7C);
    px(128, 8);
    chk("edge_en", font_en, 0);
    px(300, 300);
    chk("edge_pix", pix_on, 0);

    // write and read of the same cell in one cycle
    wr(0, 15);
    px(1, 0);
    wr_en = 1; wr_addr = '0; wr_char = 4'h8;
    #1 chk("rw_same", font_char, 4'hF);
    hcount = 10'd2; vcount = 10'd0;
    step();
    wr_en = 0;
    chk("rw_next", font_char, 4'h8);

    // blinking cursor over a blank buffer; frame 0 is the one in progress at reset
    reset_n = 0; px(300, 300); px(300, 300); reset_n = 1;
    cursor_en = 1; cursor_addr = '0;
    for (int f = 0; f < 60; f++) begin
      clr(); n = 0;
      for (int v = 0; v < 8; v++) for (int h = 0; h < 8; h++) begin
        if (!(f == 0 && h == 0 && v == 0)) begin px(h, v); n++; end
      end
      px(300, 300); px(300, 300);
      lit = 0;
      for (int i = 1; i <= n; i++) lit += int'(hp[i]);
      chk($sformatf("blink_f%0d", f), lit, (f < 30) ? n : 0);
    end
    cursor_en = 0;
    clr();
    for (int v = 0; v < 8; v++) for (int h = 0; h < 8; h++) px(h, v);
    px(300, 300); px(300, 300);
    lit = 0;
    foreach (hp[i]) lit += int'(hp[i]);
    chk("cursor_off", lit, 0);

    // sync pulses across the text region
    wr(0, 8);
    clr();
    for (int k = 0; k < 200; k++) begin
      hsync_in    = !(k >= 20 && k < 116);
      vsync_in    = !(k >= 50 && k < 53);
      video_on_in = (k < 20 || k >= 116);
      px(k % 128, 1 + 8 * ((k / 128) % 2));
    end
    hsync_in = 1; vsync_in = 1; video_on_in = 1;
    px(300, 300); px(300, 300);
    first = -1; lows = 0;
    foreach (hh[i]) if (!hh[i]) begin lows++; if (first < 0) first = i; end
    chk("hs_first", first, 21);
    chk("hs_width", lows, 96);

    // randomized traffic, including out-of-range addresses and a mid-run reset
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        cursor_addr = AW'($urandom_range(0, 70));
        cursor_en   = 1'($urandom);
      end
      reset_n     = !(i == 700 || i == 701);
      video_on_in = ($urandom_range(0, 9) != 0);
      hsync_in    = 1'($urandom); vsync_in = 1'($urandom);
      wr_en       = ($urandom_range(0, 4) == 0);
      wr_addr     = AW'($urandom_range(0, 127));
      wr_char     = 4'($urandom);
      if ($urandom_range(0, 19) == 0) px(0, 0);
      else px($urandom_range(0, 140), $urandom_range(0, 40));
    end
    reset_n = 1; wr_en = 0;
    px(300, 300); px(300, 300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
